// File: rtl/levenshtein_pkg.sv
// Shared definitions for the Levenshtein controller's serial SRAM path.
// Holds the SPI opcodes of the external 23LC1024-style SRAM, the length of
// one single-byte frame (cmd + 24-bit address + data), and the state type
// of the Wishbone-to-SPI bridge FSM.
package levenshtein_pkg;

  localparam logic [7:0]  SPI_CMD_READ  = 8'h03;
  localparam logic [7:0]  SPI_CMD_WRITE = 8'h02;
  localparam int unsigned SPI_FRAME_LEN = 40;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE,
    GAP
  } spi_state_t;

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 shift engine for one fixed-length 40-bit frame.
// Ports:
//   clk_i, rst_ni : system clock, asynchronous active-low reset
//   start         : load frame and begin shifting (single-cycle pulse)
//   frame         : 40-bit frame to transmit, MSB first
//   miso          : serial input, sampled on SCK rising transitions
//   sck           : SPI clock, idle low, toggles every clk_i cycle when busy
//   mosi_bit      : current transmit bit (tx MSB), ungated
//   rx            : last 8 bits received, first-received bit in MSB
//   done          : high during the cycle whose edge completes the frame
module spi_shift_engine
  import levenshtein_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start,
  input  logic [39:0] frame,
  input  logic        miso,
  output logic        sck,
  output logic        mosi_bit,
  output logic [7:0]  rx,
  output logic        done
);

  logic [39:0] tx;
  logic [5:0]  cnt;
  logic        busy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx   <= '0;
      rx   <= '0;
      cnt  <= '0;
      sck  <= 1'b0;
      busy <= 1'b0;
    end else if (start) begin
      tx   <= frame;
      cnt  <= 6'(SPI_FRAME_LEN - 1);
      sck  <= 1'b0;
      busy <= 1'b1;
    end else if (busy) begin
      sck <= ~sck;
      if (!sck) begin
        // Rising SCK: sample MISO.
        rx <= {rx[6:0], miso};
      end else begin
        // Falling SCK: advance MOSI; one bit per full SCK period.
        tx <= {tx[38:0], 1'b0};
        if (cnt == '0) begin
          busy <= 1'b0;
        end else begin
          cnt <= cnt - 6'd1;
        end
      end
    end
  end

  assign mosi_bit = tx[39];
  assign done     = busy & sck & (cnt == '0);

endmodule

// File: rtl/wb_spi_sram.sv
// Wishbone classic slave bridging the Levenshtein controller's master port
// to an external serial SRAM. Every bus cycle becomes one full SPI frame:
// 8-bit opcode, 24-bit address, 8 data bits. Ack arrives 81 cycles after the
// request is sampled; chip select stays high at least 2 cycles between frames.
// Ports:
//   clk_i, rst_ni         : system clock, asynchronous active-low reset
//   wbs_cyc_i, wbs_stb_i  : Wishbone cycle / strobe
//   wbs_adr_i             : byte address (zero-extended/truncated to 24 bits)
//   wbs_we_i, wbs_dat_i   : write enable and write data
//   wbs_ack_o             : single-cycle acknowledge
//   wbs_err_o, wbs_rty_o  : always 0
//   wbs_dat_o             : read data, held until the next read completes
//   spi_cs_n_o, spi_sck_o, spi_mosi_o, spi_miso_i : SPI mode-0 pins
module wb_spi_sram
  import levenshtein_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 24,
  parameter logic [7:0]  CMD_READ   = SPI_CMD_READ,
  parameter logic [7:0]  CMD_WRITE  = SPI_CMD_WRITE
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic [ADDR_WIDTH-1:0] wbs_adr_i,
  input  logic                  wbs_we_i,
  input  logic [7:0]            wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic                  wbs_err_o,
  output logic                  wbs_rty_o,
  output logic [7:0]            wbs_dat_o,
  output logic                  spi_cs_n_o,
  output logic                  spi_sck_o,
  output logic                  spi_mosi_o,
  input  logic                  spi_miso_i
);

  spi_state_t  state_q, state_d;
  logic        cs_n_q, cs_n_d;
  logic        ack_q, ack_d;
  logic [7:0]  dat_q, dat_d;
  logic        we_q, we_d;
  logic        start;
  logic        done;
  logic        mosi_bit;
  logic [7:0]  rx;
  logic [23:0] spi_adr;
  logic [39:0] frame;

  if (ADDR_WIDTH >= 24) begin : g_adr_trunc
    assign spi_adr = wbs_adr_i[23:0];
  end else begin : g_adr_zext
    assign spi_adr = {{(24 - ADDR_WIDTH){1'b0}}, wbs_adr_i};
  end

  assign frame = {wbs_we_i ? CMD_WRITE : CMD_READ,
                  spi_adr,
                  wbs_we_i ? wbs_dat_i : 8'h00};

  spi_shift_engine u_engine (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start    (start),
    .frame    (frame),
    .miso     (spi_miso_i),
    .sck      (spi_sck_o),
    .mosi_bit (mosi_bit),
    .rx       (rx),
    .done     (done)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cs_n_q  <= 1'b1;
      ack_q   <= 1'b0;
      dat_q   <= 8'h00;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cs_n_q  <= cs_n_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cs_n_d  = cs_n_q;
    ack_d   = ack_q;
    dat_d   = dat_q;
    we_d    = we_q;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i && !ack_q) begin
          start   = 1'b1;
          we_d    = wbs_we_i;
          cs_n_d  = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Frame always runs to completion, even if the master drops cyc.
        if (done) state_d = DONE;
      end
      DONE: begin
        cs_n_d  = 1'b1;
        ack_d   = wbs_cyc_i;
        if (!we_q) dat_d = rx;
        state_d = GAP;
      end
      GAP: begin
        ack_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_err_o  = 1'b0;
  assign wbs_rty_o  = 1'b0;
  assign wbs_dat_o  = dat_q;
  assign spi_cs_n_o = cs_n_q;
  assign spi_mosi_o = mosi_bit & ~cs_n_q;

endmodule

// File: tb/tb_wb_spi_sram.sv
module tb_wb_spi_sram;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic [23:0] adr = '0;
  logic        we = 1'b0;
  logic [7:0]  wdat = '0;
  logic        ack, err, rty;
  logic [7:0]  rdat;
  logic        cs_n, sck, mosi, miso;

  // SRAM model state
  logic [39:0] mosi_sr = '0;
  int          rise_cnt = 0;
  logic [7:0]  miso_byte = 8'h00;
  logic        miso_force = 1'b0;

  // Monitors
  int          hi_run = 0;
  int          last_gap = 0;
  logic        err_rty_seen = 1'b0;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  wb_spi_sram #(
    .ADDR_WIDTH (24),
    .CMD_READ   (8'h03),
    .CMD_WRITE  (8'h02)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_adr_i  (adr),
    .wbs_we_i   (we),
    .wbs_dat_i  (wdat),
    .wbs_ack_o  (ack),
    .wbs_err_o  (err),
    .wbs_rty_o  (rty),
    .wbs_dat_o  (rdat),
    .spi_cs_n_o (cs_n),
    .spi_sck_o  (sck),
    .spi_mosi_o (mosi),
    .spi_miso_i (miso)
  );

  // SRAM model: capture MOSI on rising SCK, restart bit count on CS fall.
  always @(posedge sck or negedge cs_n) begin
    if (sck) begin
      mosi_sr  = {mosi_sr[38:0], mosi};
      rise_cnt = rise_cnt + 1;
    end else begin
      rise_cnt = 0;
    end
  end

  assign miso = miso_force ? 1'b1 :
                (rise_cnt >= 32 && rise_cnt < 40) ? miso_byte[3'(39 - rise_cnt)] : 1'b0;

  always @(negedge clk) begin
    if (err || rty) err_rty_seen = 1'b1;
    if (cs_n) begin
      hi_run = hi_run + 1;
    end else begin
      if (hi_run != 0) last_gap = hi_run;
      hi_run = 0;
    end
  end

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic req(input logic w, input logic [23:0] a, input logic [7:0] d);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
  endtask

  task automatic drop();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  // Counts posedges (first one is the request edge) until ack is seen at a
  // negedge; returns -1 on timeout.
  task automatic wait_ack(output int n);
    logic seen;
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ack) seen = 1'b1;
    end
    if (!seen) n = -1;
  endtask

  initial begin
    int n, n1, n2;
    logic ack_seen;

    repeat (2) @(negedge clk);
    check("rst_cs_n", 40'(cs_n), 40'h1);
    check("rst_sck",  40'(sck),  40'h0);
    check("rst_mosi", 40'(mosi), 40'h0);
    check("rst_ack",  40'(ack),  40'h0);
    check("rst_dat",  40'(rdat), 40'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Read 0x800001, SRAM returns 0xFE
    miso_byte = 8'hFE;
    req(1'b0, 24'h800001, 8'h00);
    wait_ack(n);
    check("rd1_latency", 40'(n - 1), 40'd81);
    check("rd1_dat",     40'(rdat), 40'hFE);
    check("rd1_mosi",    mosi_sr, {8'h03, 24'h800001, 8'h00});
    check("rd1_sck_cnt", 40'(rise_cnt), 40'd40);
    drop();
    @(negedge clk);
    check("rd1_ack_single", 40'(ack), 40'h0);
    repeat (3) @(negedge clk);

    // Write 0x000010 <- 0xA5
    req(1'b1, 24'h000010, 8'hA5);
    wait_ack(n);
    check("wr_latency", 40'(n - 1), 40'd81);
    check("wr_mosi",    mosi_sr, {8'h02, 24'h000010, 8'hA5});
    drop();
    check("wr_dat_hold", 40'(rdat), 40'hFE);
    @(negedge clk);
    check("wr_ack_single", 40'(ack), 40'h0);
    repeat (3) @(negedge clk);

    // Back-to-back reads 0x000000 / 0x000001
    miso_byte = 8'h12;
    req(1'b0, 24'h000000, 8'h00);
    wait_ack(n1);
    check("b2b_dat0", 40'(rdat), 40'h12);
    miso_byte = 8'h34;
    adr = 24'h000001;
    wait_ack(n2);
    check("b2b_dat1",  40'(rdat), 40'h34);
    check("b2b_total", 40'((n1 - 1) + n2), 40'd164);
    check("b2b_csgap", 40'(last_gap >= 2), 40'h1);
    check("b2b_mosi",  mosi_sr, {8'h03, 24'h000001, 8'h00});
    drop();
    repeat (3) @(negedge clk);

    // Abandoned read: cyc drops 30 cycles in
    miso_byte = 8'h5A;
    req(1'b0, 24'h000100, 8'h00);
    repeat (30) @(posedge clk);
    @(negedge clk);
    drop();
    ack_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ack) ack_seen = 1'b1;
    end
    check("abort_no_ack",  40'(ack_seen), 40'h0);
    check("abort_sck_cnt", 40'(rise_cnt), 40'd40);
    check("abort_cs_n",    40'(cs_n), 40'h1);
    check("abort_mosi",    mosi_sr, {8'h03, 24'h000100, 8'h00});

    // Reset 50 cycles into a write
    req(1'b1, 24'h000020, 8'h3C);
    repeat (50) @(posedge clk);
    @(negedge clk);
    check("pre_rst_sck",  40'(sck),  40'h1);
    check("pre_rst_cs_n", 40'(cs_n), 40'h0);
    rst_n = 1'b0;
    drop();
    #1;
    check("mid_rst_cs_n", 40'(cs_n), 40'h1);
    check("mid_rst_sck",  40'(sck),  40'h0);
    check("mid_rst_ack",  40'(ack),  40'h0);
    check("mid_rst_mosi", 40'(mosi), 40'h0);
    check("mid_rst_dat",  40'(rdat), 40'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    miso_byte = 8'h77;
    req(1'b0, 24'h000030, 8'h00);
    wait_ack(n);
    check("post_rst_latency", 40'(n - 1), 40'd81);
    check("post_rst_dat",     40'(rdat), 40'h77);
    drop();
    repeat (3) @(negedge clk);

    // All-ones address with MISO held high
    miso_force = 1'b1;
    req(1'b0, 24'hFFFFFF, 8'h00);
    wait_ack(n);
    check("ff_latency", 40'(n - 1), 40'd81);
    check("ff_mosi",    mosi_sr, {8'h03, 24'hFFFFFF, 8'h00});
    check("ff_dat",     40'(rdat), 40'hFF);
    drop();
    miso_force = 1'b0;
    repeat (3) @(negedge clk);

    check("err_rty_zero", 40'(err_rty_seen), 40'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
